// File: rtl/mix_muldiv.sv
// Sign-magnitude MIX multiply/divide: shift-add MUL (STEP_BITS bits/cycle), restoring DIV (1 bit/cycle).
// Latency start->done: W/STEP_BITS+1 cycles for MUL, W+1 for DIV; results held until the next done.
// No backpressure: start is only sampled in IDLE, so requests while busy or in the done cycle are dropped.
module mix_muldiv #(
    parameter int BYTE_BITS = 6,
    parameter int BYTES     = 5,
    parameter int STEP_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       op,
    input  logic [BYTE_BITS*BYTES:0]   a_in,
    input  logic [BYTE_BITS*BYTES:0]   x_in,
    input  logic [BYTE_BITS*BYTES:0]   v_in,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_BITS*BYTES:0]   a_out,
    output logic [BYTE_BITS*BYTES:0]   x_out,
    output logic                       overflow
);
    localparam int W     = BYTE_BITS * BYTES;
    localparam int N_MUL = W / STEP_BITS;
    localparam int CW    = $clog2(W + 1);
    localparam int AW    = W + STEP_BITS;

    if ((W % STEP_BITS) != 0) begin : g_bad_step
        $error("mix_muldiv: word width must be a multiple of STEP_BITS");
    end

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W:0]     a_cap;
    logic [W:0]     x_cap;
    logic           sv;
    logic [W-1:0]   vmag;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           ovf_r;

    logic [AW-1:0]  mul_sum;
    logic [W-1:0]   mul_hi_nx;
    logic [W-1:0]   mul_lo_nx;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   div_hi_nx;
    logic [W-1:0]   div_lo_nx;
    logic           ovf_now;
    logic           ovf_fin;
    logic           last;

    // hi/lo form one 2W-bit shift register shared by both ops:
    // MUL keeps partial product in hi and remaining multiplier in lo,
    // DIV keeps the partial remainder in hi and dividend/quotient bits in lo.
    always_comb begin
        mul_sum   = AW'(hi) + AW'(vmag) * AW'(lo[STEP_BITS-1:0]);
        mul_hi_nx = mul_sum[AW-1:STEP_BITS];
        mul_lo_nx = W'({mul_sum[STEP_BITS-1:0], lo} >> STEP_BITS);
        div_trial = {hi, lo[W-1]};
        div_ge    = div_trial >= {1'b0, vmag};
        div_hi_nx = div_ge ? W'(div_trial - {1'b0, vmag}) : div_trial[W-1:0];
        div_lo_nx = W'({lo, div_ge});
        ovf_now   = (vmag == '0) || (hi >= vmag);
        ovf_fin   = (cnt == CW'(W)) ? ovf_now : ovf_r;
        last      = (cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_cap    <= '0;
            x_cap    <= '0;
            sv       <= 1'b0;
            vmag     <= '0;
            hi       <= '0;
            lo       <= '0;
            ovf_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_out    <= '0;
            x_out    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_cap <= a_in;
                        x_cap <= x_in;
                        sv    <= v_in[W];
                        vmag  <= v_in[W-1:0];
                        busy  <= 1'b1;
                        if (op) begin
                            state <= DIV;
                            cnt   <= CW'(W);
                            hi    <= a_in[W-1:0];
                            lo    <= x_in[W-1:0];
                        end else begin
                            state <= MUL;
                            cnt   <= CW'(N_MUL);
                            hi    <= '0;
                            lo    <= a_in[W-1:0];
                        end
                    end
                end
                MUL: begin
                    hi  <= mul_hi_nx;
                    lo  <= mul_lo_nx;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        a_out    <= {a_cap[W] ^ sv, mul_hi_nx};
                        x_out    <= {a_cap[W] ^ sv, mul_lo_nx};
                        overflow <= 1'b0;
                    end
                end
                DIV: begin
                    hi  <= div_hi_nx;
                    lo  <= div_lo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(W)) begin
                        ovf_r <= ovf_now;
                    end
                    if (last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Overflowed divides still run the full latency, then return the operands untouched.
                        if (ovf_fin) begin
                            a_out    <= a_cap;
                            x_out    <= x_cap;
                            overflow <= 1'b1;
                        end else begin
                            a_out    <= {a_cap[W] ^ sv, div_lo_nx};
                            x_out    <= {a_cap[W], div_hi_nx};
                            overflow <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_muldiv.sv
// Directed bench for mix_muldiv: default instance plus STEP_BITS=1/3/5 instances sharing stimulus.
// Cycle 0 is the cycle start is driven in; done is expected to be visible in cycle L.
// Each scenario task checks its own results against hand-computed values.
module tb_mix_muldiv;
    localparam int W = 30;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W:0]   a_in = '0;
    logic [W:0]   x_in = '0;
    logic [W:0]   v_in = '0;

    logic         busy, done, overflow;
    logic [W:0]   a_out, x_out;
    logic         r1_busy, r1_done, r1_ovf;
    logic [W:0]   r1_a, r1_x;
    logic         r3_busy, r3_done, r3_ovf;
    logic [W:0]   r3_a, r3_x;
    logic         r5_busy, r5_done, r5_ovf;
    logic [W:0]   r5_a, r5_x;

    int errors = 0;
    int checks = 0;

    mix_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .x_in(x_in), .v_in(v_in),
        .busy(busy), .done(done), .a_out(a_out), .x_out(x_out), .overflow(overflow)
    );
    mix_muldiv #(.STEP_BITS(1)) dut_r1 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .x_in(x_in), .v_in(v_in),
        .busy(r1_busy), .done(r1_done), .a_out(r1_a), .x_out(r1_x), .overflow(r1_ovf)
    );
    mix_muldiv #(.STEP_BITS(3)) dut_r3 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .x_in(x_in), .v_in(v_in),
        .busy(r3_busy), .done(r3_done), .a_out(r3_a), .x_out(r3_x), .overflow(r3_ovf)
    );
    mix_muldiv #(.STEP_BITS(5)) dut_r5 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .x_in(x_in), .v_in(v_in),
        .busy(r5_busy), .done(r5_done), .a_out(r5_a), .x_out(r5_x), .overflow(r5_ovf)
    );

    always #5 clk = ~clk;

    // Stimulus only: issues one op and returns the cycle done appeared (0 = never within budget).
    task automatic run_op(input logic o, input logic [W:0] a, input logic [W:0] x,
                          input logic [W:0] v, output int lat);
        lat = 0;
        @(posedge clk); #1;
        op = o; a_in = a; x_in = x; v_in = v; start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, overflow});
        end
        checks++;
        if (a_out !== '0) begin
            errors++; $display("FAIL reset_a: got %h expected 0", a_out);
        end
        checks++;
        if (x_out !== '0) begin
            errors++; $display("FAIL reset_x: got %h expected 0", x_out);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_mul_basic();
        int lat = 0;
        logic b1 = 1'b0, b15 = 1'b0, b16 = 1'b1, d15 = 1'b1;
        @(posedge clk); #1;
        op = 1'b0; a_in = {1'b0, 30'd2}; x_in = {1'b1, 30'd999}; v_in = {1'b1, 30'd3}; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin start = 1'b0; b1 = busy; end
            if (c == 15) begin b15 = busy; d15 = done; end
            if (c == 16) b16 = busy;
            if (done && lat == 0) lat = c;
        end
        checks++;
        if ({b1, b15, d15, b16} !== 4'b1100) begin
            errors++; $display("FAIL mul_busy: got b1/b15/d15/b16=%b expected 1100", {b1, b15, d15, b16});
        end
        checks++;
        if (lat !== 16) begin
            errors++; $display("FAIL mul_latency: got %0d expected 16", lat);
        end
        checks++;
        if (a_out !== {1'b1, 30'd0}) begin
            errors++; $display("FAIL mul_a: got %h expected %h", a_out, {1'b1, 30'd0});
        end
        checks++;
        if (x_out !== {1'b1, 30'd6}) begin
            errors++; $display("FAIL mul_x: got %h expected %h", x_out, {1'b1, 30'd6});
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL mul_ovf: got %b expected 0", overflow);
        end
    endtask

    task automatic test_mul_radix();
        int l2 = 0, l1 = 0, l3 = 0, l5 = 0;
        logic [W:0] a2 = '0, x2 = '0, a1 = '0, x1 = '0, a3 = '0, x3 = '0, a5 = '0, x5 = '0;
        logic [W:0] ea, ex;
        ea = {1'b0, 30'd1073741822};
        ex = {1'b0, 30'd1};
        repeat (40) @(posedge clk);
        #1;
        op = 1'b0; a_in = {1'b0, 30'h3FFF_FFFF}; x_in = '0; v_in = {1'b0, 30'h3FFF_FFFF}; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (done && l2 == 0) begin l2 = c; a2 = a_out; x2 = x_out; end
            if (r1_done && l1 == 0) begin l1 = c; a1 = r1_a; x1 = r1_x; end
            if (r3_done && l3 == 0) begin l3 = c; a3 = r3_a; x3 = r3_x; end
            if (r5_done && l5 == 0) begin l5 = c; a5 = r5_a; x5 = r5_x; end
        end
        checks++;
        if (l2 !== 16 || a2 !== ea || x2 !== ex) begin
            errors++; $display("FAIL max_mul_s2: got lat=%0d a=%h x=%h expected lat=16 a=%h x=%h", l2, a2, x2, ea, ex);
        end
        checks++;
        if (l1 !== 31 || a1 !== ea || x1 !== ex) begin
            errors++; $display("FAIL max_mul_s1: got lat=%0d a=%h x=%h expected lat=31 a=%h x=%h", l1, a1, x1, ea, ex);
        end
        checks++;
        if (l3 !== 11 || a3 !== ea || x3 !== ex) begin
            errors++; $display("FAIL max_mul_s3: got lat=%0d a=%h x=%h expected lat=11 a=%h x=%h", l3, a3, x3, ea, ex);
        end
        checks++;
        if (l5 !== 7 || a5 !== ea || x5 !== ex) begin
            errors++; $display("FAIL max_mul_s5: got lat=%0d a=%h x=%h expected lat=7 a=%h x=%h", l5, a5, x5, ea, ex);
        end
    endtask

    task automatic test_div();
        int lat;
        run_op(1'b1, {1'b0, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd5}, lat);
        checks++;
        if (lat !== 31) begin
            errors++; $display("FAIL div_latency: got %0d expected 31", lat);
        end
        checks++;
        if (a_out !== {1'b0, 30'd3} || x_out !== {1'b0, 30'd2} || overflow !== 1'b0) begin
            errors++; $display("FAIL div_pos: got a=%h x=%h ovf=%b expected a=%h x=%h ovf=0",
                               a_out, x_out, overflow, {1'b0, 30'd3}, {1'b0, 30'd2});
        end
        run_op(1'b1, {1'b1, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd5}, lat);
        checks++;
        if (a_out !== {1'b1, 30'd3} || x_out !== {1'b1, 30'd2}) begin
            errors++; $display("FAIL div_negzero: got a=%h x=%h expected a=%h x=%h",
                               a_out, x_out, {1'b1, 30'd3}, {1'b1, 30'd2});
        end
    endtask

    task automatic test_div_overflow();
        int lat;
        run_op(1'b1, {1'b0, 30'd5}, {1'b0, 30'd0}, {1'b0, 30'd5}, lat);
        checks++;
        if (lat !== 31) begin
            errors++; $display("FAIL ovf_latency: got %0d expected 31", lat);
        end
        checks++;
        if (overflow !== 1'b1 || a_out !== {1'b0, 30'd5} || x_out !== {1'b0, 30'd0}) begin
            errors++; $display("FAIL ovf_a_ge_v: got a=%h x=%h ovf=%b expected a=%h x=0 ovf=1",
                               a_out, x_out, overflow, {1'b0, 30'd5});
        end
        run_op(1'b1, {1'b0, 30'd3}, {1'b1, 30'd7}, {1'b1, 30'd0}, lat);
        checks++;
        if (overflow !== 1'b1 || a_out !== {1'b0, 30'd3} || x_out !== {1'b1, 30'd7}) begin
            errors++; $display("FAIL ovf_v_zero: got a=%h x=%h ovf=%b expected a=%h x=%h ovf=1",
                               a_out, x_out, overflow, {1'b0, 30'd3}, {1'b1, 30'd7});
        end
        run_op(1'b1, {1'b0, 30'd0}, {1'b0, 30'd100}, {1'b1, 30'd7}, lat);
        checks++;
        if (overflow !== 1'b0 || a_out !== {1'b1, 30'd14} || x_out !== {1'b0, 30'd2}) begin
            errors++; $display("FAIL ovf_clear: got a=%h x=%h ovf=%b expected a=%h x=%h ovf=0",
                               a_out, x_out, overflow, {1'b1, 30'd14}, {1'b0, 30'd2});
        end
    endtask

    task automatic test_ignore_inputs();
        int lat = 0, ndone = 0;
        @(posedge clk); #1;
        op = 1'b0; a_in = {1'b0, 30'd1000}; x_in = '0; v_in = {1'b0, 30'd1000}; start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                a_in = {1'b1, 30'h2AAA_AAAA}; x_in = {1'b1, 30'd5}; v_in = {1'b1, 30'h1555_5555};
            end
            if (c == 4) begin start = 1'b1; op = 1'b1; end
            if (c == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
        end
        checks++;
        if (ndone !== 1 || lat !== 16) begin
            errors++; $display("FAIL ignore_start: got %0d done pulses first at %0d expected 1 at 16", ndone, lat);
        end
        checks++;
        if (a_out !== {1'b0, 30'd0} || x_out !== {1'b0, 30'd1000000} || overflow !== 1'b0) begin
            errors++; $display("FAIL ignore_operands: got a=%h x=%h ovf=%b expected a=0 x=%h ovf=0",
                               a_out, x_out, overflow, {1'b0, 30'd1000000});
        end
    endtask

    task automatic test_back_to_back();
        int d1 = 0, d2 = 0, ndone = 0;
        @(posedge clk); #1;
        op = 1'b0; a_in = {1'b0, 30'd3}; x_in = '0; v_in = {1'b0, 30'd4}; start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            if (c == 33) start = 1'b0;
        end
        checks++;
        if (ndone !== 2 || d1 !== 16 || d2 !== 33) begin
            errors++; $display("FAIL back_to_back: got %0d dones at %0d,%0d expected 2 at 16,33", ndone, d1, d2);
        end
        checks++;
        if (x_out !== {1'b0, 30'd12}) begin
            errors++; $display("FAIL b2b_result: got %h expected %h", x_out, {1'b0, 30'd12});
        end
    endtask

    task automatic test_reset_mid();
        int lat, ndone = 0;
        @(posedge clk); #1;
        op = 1'b1; a_in = {1'b0, 30'd0}; x_in = {1'b0, 30'd17}; v_in = {1'b0, 30'd5}; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow, a_out, x_out} !== '0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b ovf=%b a=%h x=%h expected all 0",
                               busy, done, overflow, a_out, x_out);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d done pulses expected 0", ndone);
        end
        run_op(1'b1, {1'b1, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd5}, lat);
        checks++;
        if (lat !== 31 || a_out !== {1'b1, 30'd3} || x_out !== {1'b1, 30'd2}) begin
            errors++; $display("FAIL reset_recover: got lat=%0d a=%h x=%h expected lat=31 a=%h x=%h",
                               lat, a_out, x_out, {1'b1, 30'd3}, {1'b1, 30'd2});
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_radix();
        test_div();
        test_div_overflow();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
